// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared opcodes, functional-unit enable indices and FSM encoding
//           for the gated ALU core.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Opcode encoding
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_CMP  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;

  // Bit positions inside the one-hot unit enable
  localparam int UNIT_ARITH = 0;  // add / sub / cmp
  localparam int UNIT_LOGIC = 1;  // logic / shift / rotate
  localparam int UNIT_MUL   = 2;
  localparam int UNIT_DIV   = 3;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Map an opcode onto the functional unit that executes it (0 for reserved)
  function automatic logic [3:0] unit_decode(input logic [3:0] op);
    logic [3:0] en;
    en = 4'b0000;
    case (op)
      OP_ADD, OP_SUB, OP_CMP:                 en[UNIT_ARITH] = 1'b1;
      OP_NAND, OP_AND, OP_NOR, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR:         en[UNIT_LOGIC] = 1'b1;
      OP_MUL:                                 en[UNIT_MUL]   = 1'b1;
      OP_DIV:                                 en[UNIT_DIV]   = 1'b1;
      default:                                en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : alu_iter_muldiv
// Purpose : Shared iterative datapath for signed multiply (shift-add) and
//           signed divide (restoring). One bit per cycle on magnitudes, sign
//           fixed up combinationally from the final registers.
// Rev     : 1.0  initial release
// ============================================================================
module alu_iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,       // asynchronous, active-low
  input  logic                    i_start,   // load operands and begin
  input  logic                    i_is_div,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic                    o_done,    // high during the last iteration
  output logic        [WIDTH-1:0] o_lo,
  output logic        [WIDTH-1:0] o_hi,
  output logic                    o_ovf
);

  localparam int CW = $clog2(WIDTH);

  logic             r_active;
  logic             r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_addend;   // multiplicand (MUL) or divisor (DIV) magnitude
  logic [WIDTH-1:0] r_hi;       // product upper half / partial remainder
  logic [WIDTH-1:0] r_lo;       // multiplier bits / dividend bits -> quotient
  logic             r_neg_q;    // product or quotient is negative
  logic             r_neg_r;    // remainder follows the dividend sign

  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_tr;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;

  assign w_ma = i_a[WIDTH-1] ? WIDTH'(-i_a) : i_a;
  assign w_mb = i_b[WIDTH-1] ? WIDTH'(-i_b) : i_b;

  // One iteration step for both algorithms; the remainder never exceeds the
  // divisor magnitude so the shifted remainder always fits in WIDTH bits.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_addend} : '0);
    w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    w_div_tr  = w_div_sh - {1'b0, r_addend};
    w_div_ge  = ~w_div_tr[WIDTH];
    if (r_div) begin
      w_hi_nxt = w_div_ge ? w_div_tr[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done = r_active & (r_cnt == CW'(WIDTH - 1));

  // Operand load on start, then one iteration per cycle until the counter ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_div    <= 1'b0;
      r_cnt    <= '0;
      r_addend <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_div    <= i_is_div;
      r_cnt    <= '0;
      r_addend <= i_is_div ? w_mb : w_ma;
      r_hi     <= '0;
      r_lo     <= i_is_div ? w_ma : w_mb;
      r_neg_q  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_neg_r  <= i_a[WIDTH-1];
    end else if (r_active) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) begin
        r_active <= 1'b0;
      end
    end
  end

  // Apply signs to the magnitude results
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo_s  = r_neg_q ? -r_lo : r_lo;
    w_rem_s  = r_neg_r ? -r_hi : r_hi;
    o_lo     = r_div ? w_quo_s : w_prod_s[WIDTH-1:0];
    o_hi     = r_div ? w_rem_s : w_prod_s[2*WIDTH-1:WIDTH];
    // Only most-negative / -1 yields a positive quotient of 2^(WIDTH-1)
    o_ovf    = r_div & ~r_neg_q & (r_lo == {1'b1, {(WIDTH-1){1'b0}}});
  end

endmodule
`default_nettype wire

// File: rtl/alu_gated_core.sv
`default_nettype none
// ============================================================================
// Module  : alu_gated_core
// Purpose : Signed ALU with per-unit operand gating, single-cycle ops and a
//           shared iterative MUL/DIV unit, controlled by an IDLE/ITER/DONE FSM.
// Rev     : 1.0  initial release
// ============================================================================
module alu_gated_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,      // asynchronous, active-low
  input  logic                    start,
  input  logic              [3:0] op,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH-1:0] Z_low,
  output logic signed [WIDTH-1:0] Z_high,
  output logic                    valid,
  output logic                    busy,
  output logic                    ovf,
  output logic                    dbz,
  output logic                    err,
  output logic              [3:0] unit_en
);

  localparam int SHW = $clog2(WIDTH);

  state_t r_state;
  state_t w_state_nxt;

  logic              w_accept;
  logic [3:0]        w_dec_en;
  logic              w_go_iter;
  logic              w_md_start;
  logic              w_md_done;
  logic [WIDTH-1:0]  w_md_lo;
  logic [WIDTH-1:0]  w_md_hi;
  logic              w_md_ovf;

  logic [3:0]              r_op;
  logic [3:0]              r_unit_en;
  logic signed [WIDTH-1:0] r_as_a;
  logic signed [WIDTH-1:0] r_as_b;
  logic [WIDTH-1:0]        r_lg_a;
  logic [WIDTH-1:0]        r_lg_b;
  logic [WIDTH-1:0]        r_div_a;
  logic                    r_b_zero;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [SHW-1:0]     w_amt;
  logic [2*WIDTH-1:0] w_rol2;
  logic [2*WIDTH-1:0] w_ror2;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic               w_res_ovf;
  logic               w_res_dbz;
  logic               w_res_err;

  assign w_accept   = start & (r_state == ST_IDLE);
  assign w_dec_en   = unit_decode(op);
  assign w_go_iter  = w_dec_en[UNIT_MUL] | (w_dec_en[UNIT_DIV] & (B != '0));
  assign w_md_start = w_accept & w_go_iter;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, busy and unit enables (live decode on the accept cycle)
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    unit_en     = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unit_en     = w_dec_en;
          w_state_nxt = w_go_iter ? ST_ITER : ST_DONE;
        end
      end
      ST_ITER: begin
        busy    = 1'b1;
        unit_en = r_unit_en;
        if (w_md_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        unit_en     = r_unit_en;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture opcode and gate operands into the unit that will execute them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= '0;
      r_unit_en <= '0;
      r_as_a    <= '0;
      r_as_b    <= '0;
      r_lg_a    <= '0;
      r_lg_b    <= '0;
      r_div_a   <= '0;
      r_b_zero  <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op;
      r_unit_en <= w_dec_en;
      if (w_dec_en[UNIT_ARITH]) begin
        r_as_a <= A;
        r_as_b <= B;
      end
      if (w_dec_en[UNIT_LOGIC]) begin
        r_lg_a <= A;
        r_lg_b <= B;
      end
      if (w_dec_en[UNIT_DIV]) begin
        r_div_a  <= A;
        r_b_zero <= (B == '0);
      end
    end
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_md_start),
    .i_is_div (w_dec_en[UNIT_DIV]),
    .i_a      (A),
    .i_b      (B),
    .o_done   (w_md_done),
    .o_lo     (w_md_lo),
    .o_hi     (w_md_hi),
    .o_ovf    (w_md_ovf)
  );

  assign w_add  = {r_as_a[WIDTH-1], r_as_a} + {r_as_b[WIDTH-1], r_as_b};
  assign w_sub  = {r_as_a[WIDTH-1], r_as_a} - {r_as_b[WIDTH-1], r_as_b};
  assign w_amt  = r_lg_b[SHW-1:0];
  assign w_rol2 = {r_lg_a, r_lg_a} << w_amt;
  assign w_ror2 = {r_lg_a, r_lg_a} >> w_amt;

  // Result selection from the latched opcode, consumed in the DONE cycle
  always_comb begin
    w_res_lo  = '0;
    w_res_hi  = '0;
    w_res_ovf = 1'b0;
    w_res_dbz = 1'b0;
    w_res_err = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res_lo  = w_add[WIDTH-1:0];
        w_res_hi  = {WIDTH{w_add[WIDTH]}};
        w_res_ovf = w_add[WIDTH] ^ w_add[WIDTH-1];
      end
      OP_SUB: begin
        w_res_lo  = w_sub[WIDTH-1:0];
        w_res_hi  = {WIDTH{w_sub[WIDTH]}};
        w_res_ovf = w_sub[WIDTH] ^ w_sub[WIDTH-1];
      end
      OP_MUL: begin
        w_res_lo = w_md_lo;
        w_res_hi = w_md_hi;
      end
      OP_DIV: begin
        if (r_b_zero) begin
          w_res_lo  = '1;
          w_res_hi  = r_div_a;
          w_res_dbz = 1'b1;
        end else begin
          w_res_lo  = w_md_lo;
          w_res_hi  = w_md_hi;
          w_res_ovf = w_md_ovf;
        end
      end
      OP_CMP: begin
        if (r_as_a < r_as_b) begin
          w_res_lo = '1;
        end else if (r_as_a > r_as_b) begin
          w_res_lo = WIDTH'(1);
        end
      end
      OP_NAND: w_res_lo = ~(r_lg_a & r_lg_b);
      OP_AND:  w_res_lo = r_lg_a & r_lg_b;
      OP_NOR:  w_res_lo = ~(r_lg_a | r_lg_b);
      OP_OR:   w_res_lo = r_lg_a | r_lg_b;
      OP_XOR:  w_res_lo = r_lg_a ^ r_lg_b;
      OP_SHL:  w_res_lo = r_lg_a << w_amt;
      OP_SHR:  w_res_lo = r_lg_a >> w_amt;
      OP_ROL:  w_res_lo = w_rol2[2*WIDTH-1:WIDTH];
      OP_ROR:  w_res_lo = w_ror2[WIDTH-1:0];
      default: w_res_err = 1'b1;
    endcase
  end

  // Result and flag registers: update and pulse valid only out of DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Z_low  <= '0;
      Z_high <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (r_state == ST_DONE) begin
        valid  <= 1'b1;
        Z_low  <= w_res_lo;
        Z_high <= w_res_hi;
        ovf    <= w_res_ovf;
        dbz    <= w_res_dbz;
        err    <= w_res_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_gated_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_gated_core
// Purpose : Directed self-checking bench for alu_gated_core (WIDTH=16).
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_gated_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Z_low;
  logic [15:0] Z_high;
  logic        valid;
  logic        busy;
  logic        ovf;
  logic        dbz;
  logic        err;
  logic [3:0]  unit_en;

  int n_chk = 0;
  int n_err = 0;

  alu_gated_core #(.WIDTH(16)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .Z_low   (Z_low),
    .Z_high  (Z_high),
    .valid   (valid),
    .busy    (busy),
    .ovf     (ovf),
    .dbz     (dbz),
    .err     (err),
    .unit_en (unit_en)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble inputs after accept, then check latency,
  // busy length, unit enables, results, flags and the one-cycle valid pulse.
  task automatic run_op(input string tag, input logic [3:0] t_op,
                        input logic [15:0] t_a, input logic [15:0] t_b,
                        input int lat, input logic [3:0] en,
                        input logic [15:0] lo, input logic [15:0] hi,
                        input logic [2:0] fl);
    int k;
    int nb;
    bit got;
    bit en_ok;
    @(negedge clk);
    op = t_op; A = t_a; B = t_b; start = 1'b1;
    #1;
    en_ok = (unit_en === en);
    @(posedge clk);
    #1;
    start = 1'b0; A = ~t_a; B = ~t_b; op = 4'hE;
    k = 0; nb = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (busy) begin
        nb++;
        if (unit_en !== en) en_ok = 1'b0;
      end
      if (valid) got = 1'b1;
    end
    check_val({tag, "/valid"},   32'(got), 32'd1);
    check_val({tag, "/latency"}, k, lat);
    check_val({tag, "/busy"},    nb, lat - 1);
    check_val({tag, "/unit_en"}, 32'(en_ok), 32'd1);
    check_val({tag, "/Z"},       {Z_high, Z_low}, {hi, lo});
    check_val({tag, "/flags"},   {ovf, dbz, err}, fl);
    @(negedge clk);
    check_val({tag, "/after"}, {valid, busy, unit_en, Z_low}, {1'b0, 1'b0, 4'b0000, lo});
  endtask

  initial begin
    int nv;
    logic [15:0] cap_lo;
    logic [15:0] cap_hi;

    rst = 1'b0; start = 1'b0; op = 4'h0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check_val("reset/Z", {Z_high, Z_low}, 32'h0);
    check_val("reset/ctl", {valid, busy, ovf, dbz, err, unit_en}, 9'h0);
    rst = 1'b1;

    //      tag         op     A        B        lat en       Z_low    Z_high   {ovf,dbz,err}
    run_op("add_ovf",  4'h0, 16'h7FFF, 16'h0001, 2,  4'b0001, 16'h8000, 16'h0000, 3'b100);
    run_op("sub_ovf",  4'h1, 16'h8000, 16'h0001, 2,  4'b0001, 16'h7FFF, 16'hFFFF, 3'b100);
    run_op("add_neg",  4'h0, 16'hFFFF, 16'hFFFF, 2,  4'b0001, 16'hFFFE, 16'hFFFF, 3'b000);
    run_op("mul_m3x7", 4'h2, 16'hFFFD, 16'h0007, 18, 4'b0100, 16'hFFEB, 16'hFFFF, 3'b000);
    run_op("mul_min2", 4'h2, 16'h8000, 16'h8000, 18, 4'b0100, 16'h0000, 16'h4000, 3'b000);
    run_op("mul_mix",  4'h2, 16'd300,  16'hFF38, 18, 4'b0100, 16'h15A0, 16'hFFFF, 3'b000);
    run_op("div_m7d2", 4'h3, 16'hFFF9, 16'h0002, 18, 4'b1000, 16'hFFFD, 16'hFFFF, 3'b000);
    run_op("div_zero", 4'h3, 16'h0005, 16'h0000, 2,  4'b1000, 16'hFFFF, 16'h0005, 3'b010);
    run_op("div_ovf",  4'h3, 16'h8000, 16'hFFFF, 18, 4'b1000, 16'h8000, 16'h0000, 3'b100);
    run_op("div_mix",  4'h3, 16'd100,  16'hFFF9, 18, 4'b1000, 16'hFFF2, 16'h0002, 3'b000);
    run_op("cmp_lt",   4'h4, 16'h0002, 16'h0009, 2,  4'b0001, 16'hFFFF, 16'h0000, 3'b000);
    run_op("cmp_eq",   4'h4, 16'h0005, 16'h0005, 2,  4'b0001, 16'h0000, 16'h0000, 3'b000);
    run_op("cmp_gt",   4'h4, 16'hFFFF, 16'hFFFB, 2,  4'b0001, 16'h0001, 16'h0000, 3'b000);
    run_op("nand",     4'h5, 16'hF0F0, 16'h3C3C, 2,  4'b0010, 16'hCFCF, 16'h0000, 3'b000);
    run_op("and",      4'h6, 16'hF0F0, 16'h3C3C, 2,  4'b0010, 16'h3030, 16'h0000, 3'b000);
    run_op("nor",      4'h7, 16'hF0F0, 16'h3C3C, 2,  4'b0010, 16'h0303, 16'h0000, 3'b000);
    run_op("or",       4'h8, 16'hF0F0, 16'h3C3C, 2,  4'b0010, 16'hFCFC, 16'h0000, 3'b000);
    run_op("xor",      4'h9, 16'hF0F0, 16'h3C3C, 2,  4'b0010, 16'hCCCC, 16'h0000, 3'b000);
    run_op("shl",      4'hA, 16'h0001, 16'h0014, 2,  4'b0010, 16'h0010, 16'h0000, 3'b000);
    run_op("shr",      4'hB, 16'h8000, 16'h000F, 2,  4'b0010, 16'h0001, 16'h0000, 3'b000);
    run_op("rol",      4'hC, 16'h8001, 16'h0001, 2,  4'b0010, 16'h0003, 16'h0000, 3'b000);
    run_op("ror",      4'hD, 16'h0001, 16'h0011, 2,  4'b0010, 16'h8000, 16'h0000, 3'b000);
    run_op("reserved", 4'hF, 16'h1234, 16'h5678, 2,  4'b0000, 16'h0000, 16'h0000, 3'b001);

    // A start issued while a MUL iterates must be dropped, not queued
    @(negedge clk);
    op = 4'h2; A = 16'hFFFD; B = 16'h0007; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("ignore/busy", 32'(busy), 32'd1);
    op = 4'h0; A = 16'h0001; B = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nv = 0; cap_lo = '0; cap_hi = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        cap_lo = Z_low;
        cap_hi = Z_high;
      end
    end
    check_val("ignore/pulses", nv, 1);
    check_val("ignore/Z", {cap_hi, cap_lo}, 32'hFFFF_FFEB);
    run_op("add_after", 4'h0, 16'h0001, 16'h0001, 2, 4'b0001, 16'h0002, 16'h0000, 3'b000);

    // Reset in the middle of a DIV aborts it immediately and silently
    @(negedge clk);
    op = 4'h3; A = 16'hFFF9; B = 16'h0002; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rstmid/busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_val("rstmid/Z", {Z_high, Z_low}, 32'h0);
    check_val("rstmid/ctl", {valid, busy, ovf, dbz, err, unit_en}, 9'h0);
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    check_val("rstmid/no_valid", nv, 0);
    run_op("cmp_post", 4'h4, 16'h0002, 16'h0009, 2, 4'b0001, 16'hFFFF, 16'h0000, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
